// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg (package)
// Purpose  : Shared constants for the CPU memory-stage data responder:
//            FSM state encoding, default wait states, default storage depth
//            and the byte-to-doubleword address shift. Also provides the
//            address error check shared by the responder.
// Ports    : n/a (package)
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Responder FSM encoding
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  localparam int c_DEF_WAIT_CYCLES = 2;
  localparam int c_DEF_DEPTH       = 32;

  // Byte address -> doubleword index
  localparam int c_DW_SHIFT = 3;

  // A request is in error when it is not doubleword aligned or its
  // doubleword index falls outside the storage.
  function automatic logic addr_error(input logic [63:0] addr, input int depth);
    logic [63:0] idx;
    idx = addr >> c_DW_SHIFT;
    return (addr[c_DW_SHIFT-1:0] != '0) || (idx >= 64'(depth));
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Purpose  : Doubleword data storage. Synchronous write, asynchronous read,
//            whole array cleared asynchronously by reset.
// Ports    : clk    - clock
//            reset  - asynchronous active-high clear
//            we     - write enable (caller guarantees waddr < DEPTH)
//            waddr  - write doubleword index
//            wdata  - write data
//            raddr  - read doubleword index
//            rdata  - combinational read data
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array
  import cpu_pkg::*;
#(
  parameter int DEPTH   = c_DEF_DEPTH,
  parameter int INDEX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [INDEX_W-1:0] waddr,
  input  logic [63:0]        wdata,
  input  logic [INDEX_W-1:0] raddr,
  output logic [63:0]        rdata
);

  logic [63:0] r_mem [DEPTH];

  // Reset clears every word so a load after reset always returns zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : CPU memory-stage data responder. Accepts one LDUR/STUR request
//            at a time, inserts WAIT_CYCLES wait states, then presents a
//            registered response held until the CPU accepts it.
// Ports    : clk        - clock, all state changes on rising edge
//            reset      - asynchronous active-high reset
//            req_valid  - request present
//            req_write  - 1 store, 0 load
//            req_addr   - byte address
//            req_wdata  - store data
//            req_ready  - responder idle, request accepted this edge
//            rsp_valid  - response present
//            rsp_ready  - CPU takes response this edge
//            rsp_rdata  - load data (0 for stores and errors)
//            rsp_error  - misaligned or out-of-range request
//            busy       - stall request, high whenever not idle
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
  import cpu_pkg::*;
#(
  parameter int DEPTH       = c_DEF_DEPTH,
  parameter int WAIT_CYCLES = c_DEF_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy
);

  localparam int         c_INDEX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam bit         c_ZERO_WAIT = (WAIT_CYCLES == 0);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic        r_rsp_valid;
  logic [63:0] r_rsp_rdata;
  logic        r_rsp_error;

  logic                 w_idle;
  logic                 w_accept;
  logic                 w_txn_write;
  logic [63:0]          w_txn_addr;
  logic [63:0]          w_txn_wdata;
  logic                 w_txn_error;
  logic [c_INDEX_W-1:0] w_txn_index;
  logic                 w_to_resp;
  logic                 w_mem_we;
  logic [63:0]          w_mem_rdata;

  assign w_idle   = (r_state == c_IDLE);
  assign w_accept = req_valid && w_idle;

  // With zero wait states the response is produced on the acceptance edge
  // itself, before the latched copy exists, so the live request is used
  // while idle and the latched copy otherwise.
  assign w_txn_write = w_idle ? req_write : r_write;
  assign w_txn_addr  = w_idle ? req_addr  : r_addr;
  assign w_txn_wdata = w_idle ? req_wdata : r_wdata;

  assign w_txn_error = addr_error(w_txn_addr, DEPTH);
  assign w_txn_index = w_txn_addr[c_DW_SHIFT +: c_INDEX_W];

  // Edge that enters RESP: storage commit and load capture happen here.
  // r_cnt <= 1 rather than == 1 so a stray zero count cannot hang in WAIT.
  assign w_to_resp = (w_accept && c_ZERO_WAIT) ||
                     ((r_state == c_WAIT) && (r_cnt <= 4'd1));

  assign w_mem_we = w_to_resp && w_txn_write && !w_txn_error;

  dmem_array #(
    .DEPTH   (DEPTH),
    .INDEX_W (c_INDEX_W)
  ) u_dmem_array (
    .clk   (clk),
    .reset (reset),
    .we    (w_mem_we),
    .waddr (w_txn_index),
    .wdata (w_txn_wdata),
    .raddr (w_txn_index),
    .rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= c_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (c_ZERO_WAIT) begin
              r_state <= c_RESP;
            end else begin
              r_state <= c_WAIT;
              r_cnt   <= c_WAIT_LOAD;
            end
          end
        end
        c_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (w_to_resp) begin
            r_state <= c_RESP;
          end
        end
        c_RESP: begin
          if (rsp_ready) begin
            r_state     <= c_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase

      // Response registers load only on the edge entering RESP and then
      // hold until the CPU takes the response.
      if (w_to_resp) begin
        r_rsp_valid <= 1'b1;
        r_rsp_error <= w_txn_error;
        r_rsp_rdata <= (w_txn_write || w_txn_error) ? 64'd0 : w_mem_rdata;
      end
    end
  end

  assign req_ready = w_idle;
  assign busy      = !w_idle;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_error = r_rsp_error;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Self-checking bench for data_mem_responder. One instance uses
//            the default two wait states, a second uses zero wait states.
//            Expected responses are queued when a request is driven and
//            compared when the response appears.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int WC = 2;

  typedef struct packed {
    logic [63:0] d;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;

  logic        req_valid, req_write, req_ready, rsp_valid, rsp_ready, rsp_error, busy;
  logic [63:0] req_addr, req_wdata, rsp_rdata;

  logic        req_valid_z, req_write_z, req_ready_z, rsp_valid_z, rsp_ready_z, rsp_error_z, busy_z;
  logic [63:0] req_addr_z, req_wdata_z, rsp_rdata_z;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t sbz[$];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(32), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .busy(busy)
  );

  data_mem_responder #(.DEPTH(32), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_z), .req_write(req_write_z), .req_addr(req_addr_z),
    .req_wdata(req_wdata_z), .req_ready(req_ready_z),
    .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z),
    .rsp_error(rsp_error_z), .busy(busy_z)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Full transaction on the two-wait-state instance. Called at a negedge
  // while idle; returns at a negedge after the response has been taken.
  task automatic txn(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                     input logic [63:0] exp_d, input logic exp_e, input int hold);
    exp_t e;
    int   lat;
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    e.d = exp_d;
    e.e = exp_e;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    // Disturb the request inputs: the transaction must use latched values.
    req_valid = 1'b0;
    req_write = ~wr;
    req_addr  = addr ^ 64'h8;
    req_wdata = ~wd;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      chk("busy_wait", 64'(busy), 64'd1);
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(WC + 1));
    chk("sb_size", 64'(sb.size()), 64'd1);
    if (sb.size() > 0) e = sb.pop_front();
    chk("rsp_rdata", rsp_rdata, e.d);
    chk("rsp_error", 64'(rsp_error), 64'(e.e));
    chk("busy_resp", 64'(busy), 64'd1);
    if (hold > 0) begin
      rsp_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        req_valid = i[0] ? 1'b0 : 1'b1;   // pulses must be ignored
        req_addr  = 64'h40;
        req_write = 1'b1;
        @(negedge clk);
        chk("hold_valid", 64'(rsp_valid), 64'd1);
        chk("hold_rdata", rsp_rdata, e.d);
        chk("hold_error", 64'(rsp_error), 64'(e.e));
        chk("hold_req_ready", 64'(req_ready), 64'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk("post_valid", 64'(rsp_valid), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_req_ready", 64'(req_ready), 64'd1);
  endtask

  task automatic pop_cmp_z(input string tag);
    exp_t e;
    chk({tag, "_valid"}, 64'(rsp_valid_z), 64'd1);
    chk({tag, "_sb"}, 64'(sbz.size()), 64'd1);
    if (sbz.size() > 0) begin
      e = sbz.pop_front();
      chk({tag, "_rdata"}, rsp_rdata_z, e.d);
      chk({tag, "_error"}, 64'(rsp_error_z), 64'(e.e));
    end
  endtask

  task automatic drive_z(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                         input logic [63:0] exp_d, input logic exp_e);
    exp_t e;
    req_valid_z = 1'b1;
    req_write_z = wr;
    req_addr_z  = addr;
    req_wdata_z = wd;
    e.d = exp_d;
    e.e = exp_e;
    sbz.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0; req_write   = 1'b0; req_addr   = '0; req_wdata   = '0;
    rsp_ready   = 1'b1;
    req_valid_z = 1'b0; req_write_z = 1'b0; req_addr_z = '0; req_wdata_z = '0;
    rsp_ready_z = 1'b1;

    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    chk("rst_error", 64'(rsp_error), 64'd0);
    reset = 1'b0;

    // Store then load back, misaligned, out of range, unwritten word
    txn(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 64'd0, 1'b0, 0);
    txn(1'b0, 64'h10, 64'd0, 64'hDEADBEEF_CAFEF00D, 1'b0, 0);
    txn(1'b0, 64'h13, 64'd0, 64'd0, 1'b1, 0);
    txn(1'b1, 64'h100, 64'h1234_5678, 64'd0, 1'b1, 0);
    txn(1'b0, 64'hF8, 64'd0, 64'd0, 1'b0, 0);
    txn(1'b0, 64'h0, 64'd0, 64'd0, 1'b0, 0);     // index 32 must not alias 0
    txn(1'b1, 64'hF4, 64'h77, 64'd0, 1'b1, 0);   // misaligned store dropped
    txn(1'b0, 64'hF0, 64'd0, 64'd0, 1'b0, 0);

    // Back-pressure: response held for 5 cycles
    txn(1'b1, 64'h20, 64'hA5A5_5A5A_0F0F_F0F0, 64'd0, 1'b0, 0);
    txn(1'b0, 64'h20, 64'd0, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 4);
    txn(1'b1, 64'h28, 64'h99, 64'd0, 1'b0, 3);

    // Reset in WAIT aborts the pending store and clears storage
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h8; req_wdata = 64'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_busy_before", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(rsp_valid), 64'd0);
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    chk("abort_rdata", rsp_rdata, 64'd0);
    chk("abort_error", 64'(rsp_error), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
      @(negedge clk);
    end
    txn(1'b0, 64'h8, 64'd0, 64'd0, 1'b0, 0);
    txn(1'b0, 64'h10, 64'd0, 64'd0, 1'b0, 0);
    txn(1'b0, 64'h20, 64'd0, 64'd0, 1'b0, 0);

    // Zero-wait instance: response one cycle after accept, accepts every 2
    drive_z(1'b1, 64'h18, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    pop_cmp_z("z_store");
    chk("z_req_ready_resp", 64'(req_ready_z), 64'd0);
    chk("z_busy_resp", 64'(busy_z), 64'd1);
    drive_z(1'b0, 64'h18, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("z_gap_valid", 64'(rsp_valid_z), 64'd0);
    chk("z_gap_req_ready", 64'(req_ready_z), 64'd1);
    @(posedge clk);
    @(negedge clk);
    pop_cmp_z("z_load");
    drive_z(1'b0, 64'h13, 64'd0, 64'd0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("z_gap2_valid", 64'(rsp_valid_z), 64'd0);
    @(posedge clk);
    @(negedge clk);
    pop_cmp_z("z_err");
    req_valid_z = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("z_idle_busy", 64'(busy_z), 64'd0);
    chk("z_idle_valid", 64'(rsp_valid_z), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
